// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode constants, FSM state encoding and opcode-class helpers.
// Used by cpu_fetch and, when CPU_FETCH_JAL_PREDICT_EN is defined, by cpu_fetch_jal_target.
package cpu_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_RESET        = 2'd0,
    S_FETCH        = 2'd1,
    S_WAIT_RESOLVE = 2'd2
  } fetch_state_e;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
  endfunction

  function automatic logic is_jal(input logic [6:0] opcode);
    return (opcode == OPC_JAL);
  endfunction

endpackage

// File: rtl/cpu_fetch_jal_target.sv
// Combinational JAL target: sign-extended J-immediate added to the PC of the JAL.
// Only compiled when CPU_FETCH_JAL_PREDICT_EN is defined (the sole user is cpu_fetch under that macro).
`ifdef CPU_FETCH_JAL_PREDICT_EN
module cpu_fetch_jal_target
  import cpu_fetch_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:12]    i_instr_hi,
  output logic [XLEN-1:0] o_target
);

  logic [20:0]     w_imm;
  logic [XLEN-1:0] w_imm_sext;

  assign w_imm      = {i_instr_hi[31], i_instr_hi[19:12], i_instr_hi[20], i_instr_hi[30:21], 1'b0};
  assign w_imm_sext = {{(XLEN-21){w_imm[20]}}, w_imm};
  assign o_target   = i_pc + w_imm_sext;

endmodule
`endif

// File: rtl/cpu_fetch.sv
// Fetch stage behind the instruction cache: owns the PC, one lookup in flight, single output slot for decode.
// Optional macro CPU_FETCH_JAL_PREDICT_EN: JAL redirects in fetch instead of waiting for execute.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_icache_pc,
  output logic        o_icache_stall,
  input  logic        i_icache_ready,
  input  logic [31:0] i_icache_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_predicted,
  input  logic        i_resolve,
  input  logic        i_resolve_taken,
  input  logic [31:0] i_resolve_target
);

  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic         r_inflight;
  logic         w_inflight_next;

  logic         r_valid;
  logic [31:0]  r_instruction;
  logic [31:0]  r_slot_pc;
  logic         r_predicted;

  logic         w_stall;
  logic         w_launch;
  logic         w_accept;
  logic         w_ctrl_flow;
  logic         w_predict_jal;
  logic [31:0]  w_jal_target;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_resolve_target;
  logic [1:0]   w_unused_lsbs;

  // A launch needs an idle cache port and a slot that is empty or draining this cycle.
  assign w_stall  = !((r_state == S_FETCH) && !r_inflight && (!r_valid || i_ready));
  assign w_launch = !w_stall;
  // Ready without a lookup of ours outstanding is a leftover from before reset and is dropped.
  assign w_accept = i_icache_ready && r_inflight;

  assign w_ctrl_flow      = is_ctrl_flow(i_icache_rdata[6:0]);
  assign w_pc_plus4       = r_pc + PC_STEP;
  assign w_resolve_target = {i_resolve_target[31:2], 2'b00};
  assign w_unused_lsbs    = i_resolve_target[1:0];

`ifdef CPU_FETCH_JAL_PREDICT_EN
  cpu_fetch_jal_target u_jal_target (
    .i_pc       (r_pc),
    .i_instr_hi (i_icache_rdata[31:12]),
    .o_target   (w_jal_target)
  );
  assign w_predict_jal = is_jal(i_icache_rdata[6:0]);
`else
  assign w_jal_target  = r_pc;
  assign w_predict_jal = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_inflight_next = r_inflight;
    case (r_state)
      S_RESET: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_launch) begin
          w_inflight_next = 1'b1;
        end
        if (w_accept) begin
          w_inflight_next = 1'b0;
          if (w_predict_jal) begin
            w_pc_next = w_jal_target;
          end else if (w_ctrl_flow) begin
            w_state_next = S_WAIT_RESOLVE;
          end else begin
            w_pc_next = w_pc_plus4;
          end
        end
      end
      S_WAIT_RESOLVE: begin
        if (i_resolve) begin
          w_pc_next    = i_resolve_taken ? w_resolve_target : w_pc_plus4;
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_RESET;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_inflight <= w_inflight_next;
    end
  end

  // The slot is only ever written by an accepted return, which could not launch unless it was free.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid       <= 1'b0;
      r_instruction <= 32'd0;
      r_slot_pc     <= 32'd0;
      r_predicted   <= 1'b0;
    end else if (w_accept) begin
      r_valid       <= 1'b1;
      r_instruction <= i_icache_rdata;
      r_slot_pc     <= r_pc;
      r_predicted   <= w_predict_jal;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_icache_pc    = r_pc;
  assign o_icache_stall = w_stall;
  assign o_valid        = r_valid;
  assign o_instruction  = r_instruction;
  assign o_pc           = r_slot_pc;
  assign o_predicted    = r_predicted;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: cycle table for reset/throughput/backpressure, then hand sequences
// for resolve, cache misses, PC wrap, JAL handling (both macro settings) and stray returns after reset.
module tb_cpu_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JALR_W = 32'h0000_0067;
  localparam logic [31:0] BR_W   = 32'h0000_0063;
  localparam logic [31:0] JAL_W  = 32'h0080_006F;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] o_icache_pc;
  logic        o_icache_stall;
  logic        i_icache_ready;
  logic [31:0] i_icache_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_predicted;
  logic        i_resolve;
  logic        i_resolve_taken;
  logic [31:0] i_resolve_target;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  int          cache_cnt  = 0;
  logic [31:0] cache_pc   = 32'd0;
  int          miss_extra = 0;
  bit          stray_req  = 1'b0;

  cpu_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .o_icache_pc      (o_icache_pc),
    .o_icache_stall   (o_icache_stall),
    .i_icache_ready   (i_icache_ready),
    .i_icache_rdata   (i_icache_rdata),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_instruction    (o_instruction),
    .o_pc             (o_pc),
    .o_predicted      (o_predicted),
    .i_resolve        (i_resolve),
    .i_resolve_taken  (i_resolve_taken),
    .i_resolve_target (i_resolve_target)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Cache model: launch seen before an edge answers 1+miss_extra edges later; checks PC stability meanwhile.
  initial begin
    i_icache_ready = 1'b0;
    i_icache_rdata = 32'd0;
    forever begin
      @(negedge i_clock);
      if (!i_reset && cache_cnt > 0) chk("pc_stable", o_icache_pc, cache_pc);
      if (!i_reset && !o_icache_stall) begin
        if (cache_cnt > 0) chk("launch_while_busy", 32'd1, 32'd0);
        cache_pc  = o_icache_pc;
        cache_cnt = 1 + miss_extra;
      end
      @(posedge i_clock);
      #2;
      i_icache_ready = 1'b0;
      if (stray_req) begin
        i_icache_ready = 1'b1;
        i_icache_rdata = NOP;
        stray_req      = 1'b0;
      end else if (cache_cnt > 0) begin
        cache_cnt--;
        if (cache_cnt == 0) begin
          i_icache_ready = 1'b1;
          i_icache_rdata = mem_read(cache_pc);
        end
      end
    end
  end

  task automatic resolve(input bit taken, input logic [31:0] tgt, input logic [31:0] exp_pc);
    i_resolve        = 1'b1;
    i_resolve_taken  = taken;
    i_resolve_target = tgt;
    tick();
    i_resolve        = 1'b0;
    i_resolve_taken  = 1'b0;
    i_resolve_target = 32'd0;
    @(negedge i_clock);
    chk("resolve_icache_pc", o_icache_pc, exp_pc);
    chk("resolve_stall", {31'd0, o_icache_stall}, 32'd0);
    $display("resolve taken=%0d target=%h -> pc=%h", taken, tgt, o_icache_pc);
    tick();
  endtask

  task automatic wait_slot(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] next_ipc, input bit pred);
    int n = 0;
    @(negedge i_clock);
    while (!o_valid && n < 20) begin
      tick();
      @(negedge i_clock);
      n++;
    end
    chk("slot_valid", {31'd0, o_valid}, 32'd1);
    chk("slot_pc", o_pc, pc);
    chk("slot_instr", o_instruction, instr);
    chk("slot_next_icache_pc", o_icache_pc, next_ipc);
    chk("slot_predicted", {31'd0, o_predicted}, {31'd0, pred});
    $display("slot pc=%h instr=%h pred=%0d next_pc=%h", o_pc, o_instruction, o_predicted, o_icache_pc);
    tick();
  endtask

  typedef struct {
    bit          rdy;
    bit          valid;
    bit          stall;
    logic [31:0] ipc;
    logic [31:0] opc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    mem[32'h0000_010C] = JALR_W;
    mem[32'h0000_0200] = BR_W;
    mem[32'h0000_03A4] = JALR_W;
    mem[32'h0000_0208] = JALR_W;
    mem[32'h0000_0004] = JALR_W;
    mem[32'h0000_1000] = JAL_W;

    // cycle 0 is the S_RESET cycle right after reset release; 0x10C holds a JALR
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h0,   32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h0,   32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h100, NOP};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h104, 32'h0,   32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h104, NOP};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h108, 32'h0,   32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 32'h108, NOP};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 32'h108, NOP};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h108, NOP};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h10C, 32'h0,   32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h10C, 32'h10C, JALR_W};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h10C, 32'h0,   32'h0};

    i_reset          = 1'b1;
    i_ready          = 1'b1;
    i_resolve        = 1'b0;
    i_resolve_taken  = 1'b0;
    i_resolve_target = 32'd0;
    tick();
    tick();
    i_reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      i_ready = vecs[i].rdy;
      @(negedge i_clock);
      chk($sformatf("vec%0d_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_stall", i), {31'd0, o_icache_stall}, {31'd0, vecs[i].stall});
      chk($sformatf("vec%0d_icache_pc", i), o_icache_pc, vecs[i].ipc);
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_o_pc", i), o_pc, vecs[i].opc);
        chk($sformatf("vec%0d_instr", i), o_instruction, vecs[i].instr);
      end
      $display("cycle %0d rdy=%0d valid=%0d stall=%0d icache_pc=%h o_pc=%h", i, i_ready, o_valid,
               o_icache_stall, o_icache_pc, o_pc);
      tick();
    end
    i_ready = 1'b1;

    // JALR at 0x10C: redirect to the BRANCH at 0x200, which must hold fetch
    resolve(1'b1, 32'h0000_0201, 32'h0000_0200);
    wait_slot(32'h200, BR_W, 32'h200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clock);
      chk("branch_hold_stall", {31'd0, o_icache_stall}, 32'd1);
      chk("branch_hold_pc", o_icache_pc, 32'h200);
      chk("branch_hold_valid", {31'd0, o_valid}, 32'd0);
      tick();
    end
    resolve(1'b1, 32'h0000_03A7, 32'h0000_03A4);
    wait_slot(32'h3A4, JALR_W, 32'h3A4, 1'b0);
    resolve(1'b1, 32'h0000_0200, 32'h0000_0200);
    wait_slot(32'h200, BR_W, 32'h200, 1'b0);

    // not-taken branch continues at pc+4, fetched through a slow cache
    miss_extra = 3;
    resolve(1'b0, 32'h0000_0ABC, 32'h0000_0204);
    wait_slot(32'h204, NOP, 32'h208, 1'b0);
    miss_extra = 0;
    wait_slot(32'h208, JALR_W, 32'h208, 1'b0);

    resolve(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    wait_slot(32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
    wait_slot(32'h0, NOP, 32'h4, 1'b0);
    wait_slot(32'h4, JALR_W, 32'h4, 1'b0);

    resolve(1'b1, 32'h0000_1000, 32'h0000_1000);
`ifdef CPU_FETCH_JAL_PREDICT_EN
    wait_slot(32'h1000, JAL_W, 32'h1008, 1'b1);
`else
    wait_slot(32'h1000, JAL_W, 32'h1000, 1'b0);
    @(negedge i_clock);
    chk("jal_wait_stall", {31'd0, o_icache_stall}, 32'd1);
    tick();
    resolve(1'b1, 32'h0000_1008, 32'h0000_1008);
`endif
    wait_slot(32'h1008, NOP, 32'h100C, 1'b0);

    // reset while a slow lookup is outstanding; its completion must be ignored
    miss_extra = 4;
    tick();
    tick();
    i_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge i_clock);
      chk("in_reset_stall", {31'd0, o_icache_stall}, 32'd1);
      chk("in_reset_valid", {31'd0, o_valid}, 32'd0);
    end
    tick();
    miss_extra = 0;
    i_reset    = 1'b0;
    @(negedge i_clock);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_pc", o_pc, 32'd0);
    chk("rst_instr", o_instruction, 32'd0);
    chk("rst_predicted", {31'd0, o_predicted}, 32'd0);
    chk("rst_stall", {31'd0, o_icache_stall}, 32'd1);
    chk("rst_icache_pc", o_icache_pc, 32'h100);
    tick();
    stray_req = 1'b1;
    @(negedge i_clock);
    chk("stray_cycle_valid", {31'd0, o_valid}, 32'd0);
    chk("stray_cycle_pc", o_icache_pc, 32'h100);
    tick();
    @(negedge i_clock);
    chk("after_stray_valid", {31'd0, o_valid}, 32'd0);
    chk("after_stray_pc", o_icache_pc, 32'h100);
    $display("stray ready dropped: valid=%0d pc=%h", o_valid, o_icache_pc);
    tick();
    @(negedge i_clock);
    chk("first_after_reset_valid", {31'd0, o_valid}, 32'd1);
    chk("first_after_reset_o_pc", o_pc, 32'h100);
    chk("first_after_reset_next_pc", o_icache_pc, 32'h104);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
